// File: rtl/hybrid_tree.sv
// ---------------------------------------------------------------------------
// hybrid_tree
//   Max-priority queue with 16 entries, stored as 4 groups. Each group holds
//   one "top" register and a 3-node binary max-heap (root + 2 children). The
//   top register always holds the group maximum, so the global maximum is a
//   4-way compare over the group tops.
//
//   Every accepted operation updates storage on its acceptance edge. The
//   block then stays busy for 4 more edges and ignores requests during that
//   time. The next request is taken on the 5th edge after acceptance.
//
// Ports
//   CLK     in   sole clock, rising edge
//   RSTn    in   asynchronous reset, active HIGH (legacy name)
//   i_wrt   in   write request (enqueue, or replace when i_read=1)
//   i_read  in   read request (dequeue, or replace when i_wrt=1)
//   i_data  in   key for enqueue / replace
//   o_full  out  stored count == QUEUE_SIZE
//   o_empty out  stored count == 0
//   o_data  out  current maximum key, 0 when empty
// ---------------------------------------------------------------------------
module hybrid_tree #(
  parameter int QUEUE_SIZE = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_wrt,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int NUM_GROUPS = 4;
  localparam int CNT_W      = $clog2(QUEUE_SIZE + 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t                state_q;
  logic [2:0]            busy_cnt_q;

  logic [DATA_WIDTH-1:0] top_q  [NUM_GROUPS];
  logic [DATA_WIDTH-1:0] node_q [NUM_GROUPS][3];
  logic [2:0]            gcnt_q [NUM_GROUPS];
  logic [CNT_W-1:0]      total_q;

  logic                  full_w;
  logic                  empty_w;
  logic                  do_enq;
  logic                  do_deq;
  logic                  do_rep;
  logic                  do_any;

  logic                  has_any;
  logic [DATA_WIDTH-1:0] best;
  logic [1:0]            sel;
  logic [1:0]            tgt;
  logic [2:0]            min_cnt;

  logic [1:0]            grp;
  logic [DATA_WIDTH-1:0] cur_top;
  logic [DATA_WIDTH-1:0] cur_n0;
  logic [DATA_WIDTH-1:0] cur_n1;
  logic [DATA_WIDTH-1:0] cur_n2;
  logic [2:0]            cur_cnt;
  logic [DATA_WIDTH-1:0] top_n;
  logic [DATA_WIDTH-1:0] n0_n;
  logic [DATA_WIDTH-1:0] n1_n;
  logic [DATA_WIDTH-1:0] n2_n;
  logic [2:0]            cnt_n;
  logic [CNT_W-1:0]      total_n;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  assign full_w  = (total_q == CNT_W'(QUEUE_SIZE));
  assign empty_w = (total_q == '0);
  assign o_full  = full_w;
  assign o_empty = empty_w;

  // A replace on an empty queue degenerates to an enqueue. Enqueue on full
  // and dequeue on empty are dropped and do not start a busy window.
  assign do_enq = (state_q == ST_IDLE) && i_wrt &&
                  ((!i_read && !full_w) || (i_read && empty_w));
  assign do_deq = (state_q == ST_IDLE) && i_read && !i_wrt && !empty_w;
  assign do_rep = (state_q == ST_IDLE) && i_read && i_wrt && !empty_w;
  assign do_any = do_enq || do_deq || do_rep;

  // Selected group: largest valid top, lowest index wins ties.
  // Enqueue target: least-filled group, lowest index wins ties.
  always_comb begin
    has_any = 1'b0;
    best    = '0;
    sel     = '0;
    tgt     = '0;
    min_cnt = gcnt_q[0];
    for (int i = 0; i < NUM_GROUPS; i++) begin
      if ((gcnt_q[i] != 3'd0) && (!has_any || (top_q[i] > best))) begin
        has_any = 1'b1;
        best    = top_q[i];
        sel     = 2'(i);
      end
    end
    for (int i = 1; i < NUM_GROUPS; i++) begin
      if (gcnt_q[i] < min_cnt) begin
        min_cnt = gcnt_q[i];
        tgt     = 2'(i);
      end
    end
  end

  assign o_data = has_any ? best : '0;

  // Next contents of the single group touched by this operation. Subtree
  // slots are filled in order 0,1,2, so a group of count c has c-1 nodes.
  always_comb begin
    grp     = do_enq ? tgt : sel;
    cur_top = top_q[grp];
    cur_n0  = node_q[grp][0];
    cur_n1  = node_q[grp][1];
    cur_n2  = node_q[grp][2];
    cur_cnt = gcnt_q[grp];
    top_n   = cur_top;
    n0_n    = cur_n0;
    n1_n    = cur_n1;
    n2_n    = cur_n2;
    cnt_n   = cur_cnt;
    total_n = total_q;
    hi      = '0;
    lo      = '0;

    if (do_enq) begin
      cnt_n   = cur_cnt + 3'd1;
      total_n = total_q + CNT_W'(1);
      if (cur_cnt == 3'd0) begin
        top_n = i_data;
      end else begin
        if (i_data > cur_top) begin
          hi = i_data;
          lo = cur_top;
        end else begin
          hi = cur_top;
          lo = i_data;
        end
        top_n = hi;
        // The new subtree leaf sifts up one level to the root at most.
        case (cur_cnt)
          3'd1: n0_n = lo;
          3'd2: begin
            if (lo > cur_n0) begin
              n0_n = lo;
              n1_n = cur_n0;
            end else begin
              n1_n = lo;
            end
          end
          3'd3: begin
            if (lo > cur_n0) begin
              n0_n = lo;
              n2_n = cur_n0;
            end else begin
              n2_n = lo;
            end
          end
          default: ;
        endcase
      end
    end else if (do_deq) begin
      cnt_n   = cur_cnt - 3'd1;
      total_n = total_q - CNT_W'(1);
      // Subtree root is promoted to top; last leaf refills the root and
      // sinks one level against the only remaining child.
      case (cur_cnt)
        3'd1: top_n = '0;
        3'd2: begin
          top_n = cur_n0;
          n0_n  = '0;
        end
        3'd3: begin
          top_n = cur_n0;
          n0_n  = cur_n1;
          n1_n  = '0;
        end
        3'd4: begin
          top_n = cur_n0;
          n2_n  = '0;
          if (cur_n1 > cur_n2) begin
            n0_n = cur_n1;
            n1_n = cur_n2;
          end else begin
            n0_n = cur_n2;
            n1_n = cur_n1;
          end
        end
        default: ;
      endcase
    end else if (do_rep) begin
      if ((cur_cnt == 3'd1) || (i_data >= cur_n0)) begin
        top_n = i_data;
      end else begin
        // New key takes the root and sinks toward the larger child; a tie
        // with that child leaves the new key in place.
        top_n = cur_n0;
        n0_n  = i_data;
        if (cur_cnt == 3'd3) begin
          if (cur_n1 > i_data) begin
            n0_n = cur_n1;
            n1_n = i_data;
          end
        end else if (cur_cnt == 3'd4) begin
          if (cur_n1 >= cur_n2) begin
            if (cur_n1 > i_data) begin
              n0_n = cur_n1;
              n1_n = i_data;
            end
          end else if (cur_n2 > i_data) begin
            n0_n = cur_n2;
            n2_n = i_data;
          end
        end
      end
    end
  end

  // Storage update on acceptance plus the 4-edge busy window that follows.
  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      state_q    <= ST_IDLE;
      busy_cnt_q <= '0;
      total_q    <= '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
        top_q[g]  <= '0;
        gcnt_q[g] <= '0;
        for (int k = 0; k < 3; k++) begin
          node_q[g][k] <= '0;
        end
      end
    end else begin
      if (state_q == ST_BUSY) begin
        busy_cnt_q <= busy_cnt_q - 3'd1;
        if (busy_cnt_q == 3'd1) begin
          state_q <= ST_IDLE;
        end
      end
      if (do_any) begin
        top_q[grp]     <= top_n;
        node_q[grp][0] <= n0_n;
        node_q[grp][1] <= n1_n;
        node_q[grp][2] <= n2_n;
        gcnt_q[grp]    <= cnt_n;
        total_q        <= total_n;
        state_q        <= ST_BUSY;
        busy_cnt_q     <= 3'd4;
      end
    end
  end

endmodule

// File: tb/tb_hybrid_tree.sv
// ---------------------------------------------------------------------------
// tb_hybrid_tree
//   Self-checking bench for hybrid_tree. The reference is a plain multiset of
//   keys: enqueue adds a key, dequeue removes the largest, replace removes
//   the largest and adds the new key. Each issued request pushes its expected
//   flags (due one edge after acceptance) and expected maximum (due four
//   edges after acceptance) into a scoreboard; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_hybrid_tree;

  localparam int QS = 16;
  localparam int DW = 16;

  logic          CLK;
  logic          RSTn;
  logic          i_wrt;
  logic          i_read;
  logic [DW-1:0] i_data;
  logic          o_full;
  logic          o_empty;
  logic [DW-1:0] o_data;

  typedef struct {
    int    due;
    bit    chk_data;
    int    exp_data;
    bit    exp_full;
    bit    exp_empty;
    string name;
  } item_t;

  item_t sb_q[$];
  int    model_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  hybrid_tree #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW)) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .i_wrt  (i_wrt),
    .i_read (i_read),
    .i_data (i_data),
    .o_full (o_full),
    .o_empty(o_empty),
    .o_data (o_data)
  );

  // 10 ns clock and an edge counter used to time scoreboard entries.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int modelMax();
    int m;
    m = 0;
    foreach (model_q[i]) if (model_q[i] > m) m = model_q[i];
    return m;
  endfunction

  function automatic void modelPopMax();
    int idx;
    idx = 0;
    foreach (model_q[i]) if (model_q[i] > model_q[idx]) idx = i;
    model_q.delete(idx);
  endfunction

  // Reference behaviour of one accepted request slot.
  function automatic void modelApply(input bit wrt, input bit rd, input int data);
    if (wrt && !rd) begin
      if (model_q.size() < QS) model_q.push_back(data);
    end else if (rd && !wrt) begin
      if (model_q.size() > 0) modelPopMax();
    end else if (wrt && rd) begin
      if (model_q.size() > 0) modelPopMax();
      model_q.push_back(data);
    end
  endfunction

  // Monitor: compares every scoreboard entry whose due edge has passed.
  initial begin
    item_t it;
    forever begin
      @(negedge CLK);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        it = sb_q.pop_front();
        checkOutput({it.name, ".full"},  int'(o_full),  int'(it.exp_full));
        checkOutput({it.name, ".empty"}, int'(o_empty), int'(it.exp_empty));
        if (it.chk_data) checkOutput({it.name, ".data"}, int'(o_data), it.exp_data);
      end
    end
  end

  function automatic void pushExpect(input int c, input string name);
    item_t f;
    item_t d;
    f.due       = c + 1;
    f.chk_data  = 1'b0;
    f.exp_data  = 0;
    f.exp_full  = (model_q.size() == QS);
    f.exp_empty = (model_q.size() == 0);
    f.name      = name;
    d           = f;
    d.due       = c + 4;
    d.chk_data  = 1'b1;
    d.exp_data  = modelMax();
    sb_q.push_back(f);
    sb_q.push_back(d);
  endfunction

  // One request held for one cycle, then four idle edges of busy window.
  task automatic applyStimulus(input bit wrt, input bit rd, input int data, input string name);
    int c;
    @(negedge CLK);
    i_wrt  = wrt;
    i_read = rd;
    i_data = DW'(data);
    @(posedge CLK);
    #1;
    c = cyc;
    i_wrt  = 1'b0;
    i_read = 1'b0;
    modelApply(wrt, rd, data);
    pushExpect(c, name);
    repeat (4) @(posedge CLK);
  endtask

  task automatic applyReset();
    RSTn = 1'b1;
    sb_q.delete();
    model_q.delete();
    #1;
    checkOutput("reset.data",  int'(o_data),  0);
    checkOutput("reset.empty", int'(o_empty), 1);
    checkOutput("reset.full",  int'(o_full),  0);
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b0;
  endtask

  initial begin
    int vals[$];
    int v;
    bit dup;
    int c;
    int waited;
    int op;

    RSTn   = 1'b0;
    i_wrt  = 1'b0;
    i_read = 1'b0;
    i_data = '0;
    #2;
    applyReset();
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("idle.data",  int'(o_data),  0);
    checkOutput("idle.empty", int'(o_empty), 1);
    checkOutput("idle.full",  int'(o_full),  0);

    // Small directed sequence.
    applyStimulus(1, 0, 5, "enq5");
    applyStimulus(1, 0, 9, "enq9");
    applyStimulus(1, 0, 3, "enq3");
    applyStimulus(0, 1, 0, "deq1");
    applyStimulus(0, 1, 0, "deq2");
    applyStimulus(0, 1, 0, "deq3");
    applyStimulus(0, 1, 0, "deq_empty");
    applyStimulus(1, 1, 42, "rep_empty");
    applyStimulus(0, 1, 0, "deq42");

    // Requests inside the busy window, including its final edge, are dropped.
    @(negedge CLK);
    i_wrt  = 1'b1;
    i_read = 1'b0;
    i_data = DW'(7);
    @(posedge CLK);
    #1;
    c = cyc;
    modelApply(1, 0, 7);
    pushExpect(c, "busy_enq7");
    @(negedge CLK);
    i_wrt  = 1'b0;
    i_read = 1'b1;
    @(posedge CLK);
    #1;
    i_read = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    i_wrt  = 1'b1;
    i_data = DW'(1020);
    @(posedge CLK);
    #1;
    i_wrt  = 1'b0;
    applyStimulus(1, 0, 8, "after_busy");
    applyStimulus(0, 1, 0, "busy_deq8");
    applyStimulus(0, 1, 0, "busy_deq7");

    // Fill with 16 distinct keys, overfill, then drain.
    vals.delete();
    while (vals.size() < QS) begin
      v = int'($urandom_range(0, 1024));
      dup = 1'b0;
      foreach (vals[i]) if (vals[i] == v) dup = 1'b1;
      if (!dup) vals.push_back(v);
    end
    foreach (vals[i]) applyStimulus(1, 0, vals[i], "fill");
    applyStimulus(1, 0, 1024, "enq_full");
    for (int i = 0; i < QS; i++) applyStimulus(0, 1, 0, "drain");
    applyStimulus(0, 1, 0, "drain_empty");

    // Fill with random keys, then replace-max repeatedly.
    for (int i = 0; i < QS; i++) applyStimulus(1, 0, int'($urandom_range(0, 1024)), "rfill");
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, int'($urandom_range(0, 1024)), "replace");

    // Mixed random traffic.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      v  = int'($urandom_range(0, 1024));
      case (op)
        0:       applyStimulus(1, 0, v, "mix_enq");
        1:       applyStimulus(0, 1, 0, "mix_deq");
        default: applyStimulus(1, 1, v, "mix_rep");
      endcase
    end

    // Let the scoreboard drain before the mid-operation reset.
    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      @(posedge CLK);
      waited++;
    end
    if (sb_q.size() > 0) checkOutput("scoreboard_drain", sb_q.size(), 0);

    // Reset asserted in the middle of an operation.
    @(negedge CLK);
    i_wrt  = 1'b1;
    i_data = DW'(777);
    @(posedge CLK);
    #1;
    i_wrt  = 1'b0;
    @(posedge CLK);
    #2;
    applyReset();
    applyStimulus(1, 0, 11, "post_reset_enq");

    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      @(posedge CLK);
      waited++;
    end
    if (sb_q.size() > 0) checkOutput("final_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hybrid_tree.md
HYBRID_TREE -- requirements
Module: hybrid_tree

Interface
REQ-001 Parameter QUEUE_SIZE, default 16: total entry capacity, fixed at 4 groups x 4 entries.
REQ-002 Parameter DATA_WIDTH, default 16: key width, unsigned.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RSTn  input  1  reset, asynchronous, active-high (port name kept as used across the codebase).
REQ-005 i_wrt  input  1  write request; with i_read=0 means enqueue.
REQ-006 i_read  input  1  read request; with i_wrt=0 means dequeue, with i_wrt=1 means replace-max.
REQ-007 i_data  input  DATA_WIDTH  key for enqueue/replace.
REQ-008 o_full  output  1  high when stored count == QUEUE_SIZE.
REQ-009 o_empty  output  1  high when stored count == 0.
REQ-010 o_data  output  DATA_WIDTH  current maximum key (max-priority queue).

Function
REQ-011 Storage SHALL be 4 groups; each group = 1 top register plus a 3-node binary-heap subtree (root + 2 children); per-group count 0..4; total count register 0..16.
REQ-012 Invariant: each non-empty group's top register holds the group maximum; each subtree satisfies the max-heap property.
REQ-013 o_data SHALL be a combinational max over the valid top registers; 0 when empty; ties resolve to the lowest group index (the selected group).
REQ-014 Enqueue (count<16): target = group with smallest count, lowest index on tie; empty group -> top = i_data; else the smaller of {i_data, top} goes to the subtree at next free slot and sifts up, the larger stays top; counts +1.
REQ-015 Dequeue (count>0): selected group's top <- subtree root (if subtree non-empty); subtree last node moves to root and sifts down one level; group count and total count -1.
REQ-016 Replace (count>0): if subtree empty or i_data >= subtree root, top <- i_data; else top <- subtree root, subtree root <- i_data, sift down one level; counts unchanged.
REQ-017 Replace on empty queue SHALL behave as enqueue; enqueue when full and dequeue when empty SHALL be ignored with no state change.
REQ-018 Sift-down SHALL compare against the larger child, swap only if child > parent, ties keep the parent.
REQ-019 An accepted operation SHALL complete within 4 clock cycles; o_data SHALL show the correct maximum no later than the 4th rising edge after acceptance.
REQ-020 Requests arriving while an operation is in progress SHALL be ignored; next request accepted from the 5th edge onward.
REQ-021 o_full/o_empty SHALL update at the edge after acceptance.
REQ-022 Requests are sampled only on rising edges with i_wrt/i_read held 1 cycle; i_wrt=i_read=0 is idle.

Reset
REQ-023 RSTn high SHALL immediately clear all top registers, subtree nodes, group counts, total count and the busy state to 0.
REQ-024 During/after reset: o_data=0, o_empty=1, o_full=0; an in-flight operation is abandoned.
REQ-025 First request accepted on the first rising edge after RSTn deasserts.

Verification
REQ-026 Reset then idle -> o_empty=1, o_full=0, o_data=0.
REQ-027 Enqueue 5,9,3 with 5-cycle spacing -> o_data=9, o_empty=0; dequeue -> o_data=5; dequeue -> 3; dequeue -> o_empty=1, o_data=0.
REQ-028 Enqueue 16 distinct values 0..1024 -> o_full=1, o_data=max; extra enqueue ignored; 16 dequeues return strictly non-increasing keys, then o_empty=1.
REQ-029 Fill with 16 random keys, then 20 replaces with random keys 0..1024, 5 cycles apart -> after each, o_data equals max of a reference multiset (pop max, push new), count stays 16.
REQ-030 Request during the 4-cycle busy window -> ignored, contents and count unchanged; assert RSTn mid-operation -> all outputs return to reset values at once.
